ir_scan_sched: RTL and testbench

Scheduler that acquires the eight IR line-sensor readings consumed by the error-compute datapath. Each frame it powers the IR emitters, waits a settle time, then runs eight sequential A2D conversions through the shared A2D interface. It publishes a coherent IR_R0..IR_R3 / IR_L0..IR_L3 set with a one-cycle IR_vld pulse. It sits between the A2D/SPI interface block and the error-compute block.

---
 rtl/ir_pkg.sv | 18 +
 rtl/ir_period_timer.sv | 36 +++
 rtl/ir_scan_sched.sv | 149 ++++++++++++++
 tb/tb_ir_scan_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared constants and types for the IR line-sensor scan scheduler.
package ir_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam int unsigned ADC_W  = 12;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StStart,
        StWait,
        StDone
    } ir_state_e;

    // A2D channel for scan index 0..7 (R0,R1,R2,R3,L0,L1,L2,L3).
    localparam logic [2:0] CHNL_MAP [NUM_IR] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7, 3'd6, 3'd5};

endpackage

// File: rtl/ir_period_timer.sv
// Free-running frame timer: counts 0..PERIOD_CYCLES-1 while enabled, held at 0 otherwise.
module ir_period_timer #(
    parameter int unsigned PERIOD_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(PERIOD_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(PERIOD_CYCLES - 1));
    assign tick_o = en_i & at_end;

    // Next count: clear when disabled, wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en_i || at_end) begin
            cnt_d = '0;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_scan_sched.sv
// Per-frame IR acquisition: power emitters, settle, run eight A2D conversions, publish a coherent set.
module ir_scan_sched
    import ir_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = 1_000_000,
    parameter int unsigned SETTLE_CYCLES  = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cnv_cmplt,
    input  logic [ADC_W-1:0]  res,
    output logic              strt_cnv,
    output logic [2:0]        chnnl,
    output logic              IR_en,
    output logic [ADC_W-1:0]  IR_R0,
    output logic [ADC_W-1:0]  IR_R1,
    output logic [ADC_W-1:0]  IR_R2,
    output logic [ADC_W-1:0]  IR_R3,
    output logic [ADC_W-1:0]  IR_L0,
    output logic [ADC_W-1:0]  IR_L1,
    output logic [ADC_W-1:0]  IR_L2,
    output logic [ADC_W-1:0]  IR_L3,
    output logic              IR_vld,
    output logic              busy,
    output logic              frame_ovr,
    output logic              a2d_err
);

    // One counter serves both the settle delay and the per-conversion timeout.
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [2:0]  IDX_LAST = 3'(NUM_IR - 1);

    ir_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [ADC_W-1:0] staging_q [NUM_IR-1];
    logic [ADC_W-1:0] ir_q      [NUM_IR];
    logic             strt_cnv_q, ir_en_q, ir_vld_q, frame_ovr_q, a2d_err_q;
    logic [2:0]       chnnl_q;
    logic             tick;

    ir_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .tick_o(tick)
    );

    // Scan FSM; all outputs registered. The last reading bypasses staging so IR_* are
    // already valid in the IR_vld cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            strt_cnv_q  <= 1'b0;
            chnnl_q     <= '0;
            ir_en_q     <= 1'b0;
            ir_vld_q    <= 1'b0;
            frame_ovr_q <= 1'b0;
            a2d_err_q   <= 1'b0;
            for (int i = 0; i < NUM_IR - 1; i++) staging_q[i] <= '0;
            for (int i = 0; i < NUM_IR; i++)     ir_q[i]      <= '0;
        end else begin
            strt_cnv_q  <= 1'b0;
            ir_vld_q    <= 1'b0;
            a2d_err_q   <= 1'b0;
            frame_ovr_q <= tick && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q <= StSettle;
                        ir_en_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StSettle: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_q    <= StStart;
                        strt_cnv_q <= 1'b1;
                        chnnl_q    <= CHNL_MAP[idx_q];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnv_cmplt) begin
                        if (idx_q == IDX_LAST) begin
                            for (int i = 0; i < NUM_IR - 1; i++) ir_q[i] <= staging_q[i];
                            ir_q[NUM_IR-1] <= res;
                            ir_vld_q       <= 1'b1;
                            chnnl_q        <= '0;
                            state_q        <= StDone;
                        end else begin
                            for (int i = 0; i < NUM_IR - 1; i++) begin
                                if (idx_q == 3'(i)) staging_q[i] <= res;
                            end
                            idx_q      <= idx_q + 3'd1;
                            strt_cnv_q <= 1'b1;
                            chnnl_q    <= CHNL_MAP[idx_q + 3'd1];
                            state_q    <= StStart;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        a2d_err_q <= 1'b1;
                        ir_en_q   <= 1'b0;
                        idx_q     <= '0;
                        chnnl_q   <= '0;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    ir_en_q <= 1'b0;
                    idx_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign strt_cnv  = strt_cnv_q;
    assign chnnl     = chnnl_q;
    assign IR_en     = ir_en_q;
    assign IR_vld    = ir_vld_q;
    assign frame_ovr = frame_ovr_q;
    assign a2d_err   = a2d_err_q;
    assign busy      = (state_q != StIdle);
    assign IR_R0     = ir_q[0];
    assign IR_R1     = ir_q[1];
    assign IR_R2     = ir_q[2];
    assign IR_R3     = ir_q[3];
    assign IR_L0     = ir_q[4];
    assign IR_L1     = ir_q[5];
    assign IR_L2     = ir_q[6];
    assign IR_L3     = ir_q[7];

endmodule

// File: tb/tb_ir_scan_sched.sv
// Randomized bench for ir_scan_sched with a frame-level timing model.
module tb_ir_scan_sched;

    localparam int P     = 64;
    localparam int S     = 8;
    localparam int TO    = 16;
    localparam int NEVER = 1000;
    localparam int NPLAN = 128;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic        strt_cnv, IR_en, IR_vld, busy, frame_ovr, a2d_err;
    logic [2:0]  chnnl;
    logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3;

    ir_scan_sched #(
        .PERIOD_CYCLES (P),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .IR_en    (IR_en),
        .IR_R0    (IR_R0),
        .IR_R1    (IR_R1),
        .IR_R2    (IR_R2),
        .IR_R3    (IR_R3),
        .IR_L0    (IR_L0),
        .IR_L1    (IR_L1),
        .IR_L2    (IR_L2),
        .IR_L3    (IR_L3),
        .IR_vld   (IR_vld),
        .busy     (busy),
        .frame_ovr(frame_ovr),
        .a2d_err  (a2d_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chmap [8] = '{1, 0, 4, 2, 3, 7, 6, 5};

    // Per-frame plan: conversion wait (cycles in WAIT before cnv_cmplt) and result value.
    int plan_w [NPLAN][8];
    int plan_v [NPLAN][8];
    int rsp_fr = 0;
    int last_pub [8];

    int checks = 0, errors = 0;

    int m_strt_c[$], m_strt_ch[$], m_vld_c[$], m_vld_d[$], m_err[$], m_ovr[$], m_ien[$], m_busy[$];
    int e_strt_c[$], e_strt_ch[$], e_vld_c[$], e_vld_d[$], e_err[$], e_ovr[$], e_ien[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input int m[$], input int e[$]);
        check({tag, "_count"}, m.size(), e.size());
        for (int i = 0; i < m.size() && i < e.size(); i++) check(tag, m[i], e[i]);
    endtask

    function automatic int rand_wait();
        int p;
        p = $urandom_range(0, 99);
        if (p < 70) return $urandom_range(0, 6);
        if (p < 82) return TO - 1;
        if (p < 95) return $urandom_range(7, 14);
        return NEVER;
    endfunction

    task automatic start_phase();
        m_strt_c.delete(); m_strt_ch.delete(); m_vld_c.delete(); m_vld_d.delete();
        m_err.delete(); m_ovr.delete(); m_ien.delete(); m_busy.delete();
        e_strt_c.delete(); e_strt_ch.delete(); e_vld_c.delete(); e_vld_d.delete();
        e_err.delete(); e_ovr.delete(); e_ien.delete();
    endtask

    // Frame-level model: en high in cycles r..f-1, ticks every P cycles from r+P-1.
    task automatic predict(input int r, input int f, input int fr0);
        int busy_end, fr, s, w;
        bit ab;
        busy_end = -1;
        fr = fr0;
        for (int c = r + P - 1; c < f; c += P) begin
            if (c <= busy_end) begin
                e_ovr.push_back(c + 1);
            end else begin
                e_ien.push_back(c + 1);
                s  = c + 1 + S;
                ab = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    e_strt_c.push_back(s);
                    e_strt_ch.push_back(chmap[i]);
                    w = plan_w[fr % NPLAN][i];
                    if (w >= TO) begin
                        e_err.push_back(s + 1 + TO);
                        busy_end = s + TO;
                        ab = 1'b1;
                        break;
                    end
                    s += 2 + w;
                end
                if (!ab) begin
                    e_vld_c.push_back(s);
                    for (int i = 0; i < 8; i++) begin
                        e_vld_d.push_back(plan_v[fr % NPLAN][i]);
                        last_pub[i] = plan_v[fr % NPLAN][i];
                    end
                    busy_end = s;
                end
                e_ien.push_back(busy_end + 1);
                fr++;
            end
        end
    endtask

    task automatic compare_phase(input string ph);
        logic [11:0] cur [8];
        cmp_q({ph, ":strt_cyc"}, m_strt_c, e_strt_c);
        cmp_q({ph, ":chnnl"}, m_strt_ch, e_strt_ch);
        cmp_q({ph, ":vld_cyc"}, m_vld_c, e_vld_c);
        cmp_q({ph, ":vld_data"}, m_vld_d, e_vld_d);
        cmp_q({ph, ":a2d_err"}, m_err, e_err);
        cmp_q({ph, ":frame_ovr"}, m_ovr, e_ovr);
        cmp_q({ph, ":ir_en_edge"}, m_ien, e_ien);
        cmp_q({ph, ":busy_edge"}, m_busy, e_ien);
        cur = '{IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3};
        for (int i = 0; i < 8; i++) check({ph, ":ir_hold"}, cur[i], last_pub[i]);
    endtask

    // A2D model: answers each strt_cnv per the frame plan; injects ignored cnv_cmplt
    // pulses in START cycles and while idle.
    initial begin
        bit pi, pend;
        int cur, ridx, k, wcur, rv;
        pi = 0; pend = 0; cur = 0; ridx = 0; k = 0; wcur = 0; rv = 0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            res = 12'($urandom);
            if (!rst_n) begin
                pi = 0;
                pend = 0;
            end else begin
                if (IR_en && !pi) begin
                    cur = rsp_fr % NPLAN;
                    rsp_fr++;
                    ridx = 0;
                end
                pi = IR_en;
                if (strt_cnv) begin
                    pend = 1;
                    k = 0;
                    wcur = plan_w[cur][ridx % 8];
                    rv = plan_v[cur][ridx % 8];
                    ridx++;
                    if ($urandom_range(0, 2) == 0) cnv_cmplt = 1'b1;
                end else if (pend) begin
                    if (k == wcur) begin
                        cnv_cmplt = 1'b1;
                        res = 12'(rv);
                        pend = 0;
                    end else if (k > TO + 2) begin
                        pend = 0;
                    end
                    k++;
                end else if (!IR_en && $urandom_range(0, 7) == 0) begin
                    cnv_cmplt = 1'b1;
                end
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    initial begin
        bit pi, pb;
        pi = 0; pb = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pi = 0;
                pb = 0;
            end else begin
                if (strt_cnv) begin
                    m_strt_c.push_back(cyc);
                    m_strt_ch.push_back(int'(chnnl));
                end
                if (IR_vld) begin
                    m_vld_c.push_back(cyc);
                    m_vld_d.push_back(int'(IR_R0)); m_vld_d.push_back(int'(IR_R1));
                    m_vld_d.push_back(int'(IR_R2)); m_vld_d.push_back(int'(IR_R3));
                    m_vld_d.push_back(int'(IR_L0)); m_vld_d.push_back(int'(IR_L1));
                    m_vld_d.push_back(int'(IR_L2)); m_vld_d.push_back(int'(IR_L3));
                end
                if (a2d_err)   m_err.push_back(cyc);
                if (frame_ovr) m_ovr.push_back(cyc);
                if (IR_en !== pi) begin m_ien.push_back(cyc); pi = IR_en; end
                if (busy !== pb)  begin m_busy.push_back(cyc); pb = busy; end
            end
        end
    end

    initial begin
        int r, f, fr0, n;
        for (int j = 0; j < NPLAN; j++) begin
            for (int i = 0; i < 8; i++) begin
                plan_w[j][i] = rand_wait();
                plan_v[j][i] = $urandom_range(0, 4095);
            end
        end
        // Frames 0..2: fixed 5-cycle conversions, frame 1 never answers idx 3.
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 8; i++) begin
                plan_w[j][i] = 5;
                plan_v[j][i] = 'h100 + i + 'h10 * j;
            end
        end
        plan_w[1][3] = NEVER;
        for (int i = 0; i < 8; i++) last_pub[i] = 0;

        repeat (3) @(negedge clk);
        check("rst:IR_en", IR_en, 0);
        check("rst:busy", busy, 0);
        check("rst:strt_cnv", strt_cnv, 0);
        check("rst:chnnl", chnnl, 0);
        check("rst:IR_vld", IR_vld, 0);
        check("rst:frame_ovr", frame_ovr, 0);
        check("rst:a2d_err", a2d_err, 0);
        check("rst:IR_R0", IR_R0, 0);
        check("rst:IR_L3", IR_L3, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed: normal frame, overrun tick, timeout frame, en dropped in WAIT of idx 2.
        start_phase();
        fr0 = rsp_fr;
        r = cyc;
        en = 1'b1;
        repeat (P - 1 + 3 * P + S + 1 + 2 * 7 + 3) @(negedge clk);
        f = cyc;
        en = 1'b0;
        repeat (3 * P + 80) @(negedge clk);
        predict(r, f, fr0);
        compare_phase("dir");

        // Randomized runs.
        for (int it = 0; it < 2; it++) begin
            start_phase();
            fr0 = rsp_fr;
            r = cyc;
            en = 1'b1;
            n = $urandom_range(400, 800);
            repeat (n) @(negedge clk);
            f = cyc;
            en = 1'b0;
            repeat (220) @(negedge clk);
            predict(r, f, fr0);
            compare_phase("rnd");
        end

        // Reset during SETTLE, then a frame whose idx 3 completes on the timeout terminal count.
        for (int i = 0; i < 8; i++) begin
            plan_w[(rsp_fr + 1) % NPLAN][i] = 2;
        end
        plan_w[(rsp_fr + 1) % NPLAN][3] = TO - 1;
        en = 1'b1;
        for (int i = 0; i < 2 * P && !IR_en; i++) @(negedge clk);
        check("rstmid:frame_started", IR_en, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid:IR_en", IR_en, 0);
        check("rstmid:busy", busy, 0);
        check("rstmid:IR_R0", IR_R0, 0);
        check("rstmid:IR_L3", IR_L3, 0);
        check("rstmid:chnnl", chnnl, 0);
        for (int i = 0; i < 8; i++) last_pub[i] = 0;
        repeat (2) @(negedge clk);
        start_phase();
        fr0 = rsp_fr;
        rst_n = 1'b1;
        r = cyc;
        repeat (P + 80) @(negedge clk);
        f = cyc;
        en = 1'b0;
        repeat (220) @(negedge clk);
        predict(r, f, fr0);
        compare_phase("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
